// File: rtl/spi_gen_pkg.sv
// ---------------------------------------------------------------------------
// spi_gen_pkg : shared types and normalisation helpers for spi_mstr_gen. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_gen_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      TRAIL = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Out-of-range frame widths fall back to the widest frame.
   function automatic int unsigned norm_width(input int unsigned w, input int unsigned max_w);
      return ((w == 32'd0) || (w > max_w)) ? max_w : w;
   endfunction

   function automatic int unsigned norm_div(input int unsigned d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen : SCLK half-period divider, toggle register and edge counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_clk_gen #(
   parameter int DIV_W = 8,
   parameter int TGL_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             run,
   input  logic             tgl_en,
   input  logic [DIV_W-1:0] div_in,
   input  logic [TGL_W-1:0] ntog_in,
   input  logic             cpol_in,
   output logic             sclk,
   output logic             tick,
   output logic             tgl,
   output logic             tgl_odd,
   output logic             tgl_last
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [TGL_W-1:0] ntog_q;
   logic [TGL_W-1:0] tcnt;
   logic             sclk_q;

   assign tick     = run && (cnt == DIV_W'(1));
   assign tgl      = tick && tgl_en;
   // Parity and last-flag describe the toggle that fires on the coming edge.
   assign tgl_odd  = ~tcnt[0];
   assign tgl_last = ((tcnt + TGL_W'(1)) == ntog_q);
   assign sclk     = sclk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         cnt    <= '0;
         ntog_q <= '0;
         tcnt   <= '0;
         sclk_q <= 1'b0;
      end else if (load) begin
         div_q  <= div_in;
         cnt    <= div_in;
         ntog_q <= ntog_in;
         tcnt   <= '0;
         sclk_q <= cpol_in;
      end else if (run) begin
         if (cnt == DIV_W'(1)) begin
            cnt <= div_q;
            if (tgl_en) begin
               sclk_q <= ~sclk_q;
               tcnt   <= tcnt + TGL_W'(1);
            end
         end else begin
            cnt <= cnt - DIV_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_mstr_gen.sv
// ---------------------------------------------------------------------------
// spi_mstr_gen : parametrised SPI master, run-time width, 4 modes, MISO capture. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_mstr_gen
   import spi_gen_pkg::*;
#(
   parameter int MAX_WIDTH = 16,
   parameter int DIV_W     = 8,
   parameter int CNT_W     = $clog2(MAX_WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wrt,
   input  logic [MAX_WIDTH-1:0] data_out,
   input  logic [CNT_W-1:0]     width,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [DIV_W-1:0]     div,
   input  logic                 hold_ss,
   input  logic                 MISO,
   output logic                 SS_n,
   output logic                 SCLK,
   output logic                 MOSI,
   output logic [MAX_WIDTH-1:0] data_in,
   output logic                 busy,
   output logic                 done
);

   spi_state_t           state, state_nxt;
   spi_mode_t            mode_q, mode_nxt;
   logic                 hold_q;
   logic [MAX_WIDTH-1:0] tx_sh;
   logic [MAX_WIDTH-1:0] rx_sh;
   logic                 ss_n_q, mosi_q, busy_q, done_q;
   logic [MAX_WIDTH-1:0] data_in_q;

   logic                 accept, cg_run, tick, tgl, tgl_odd, tgl_last;
   logic                 do_shift, do_sample;
   logic [CNT_W-1:0]     width_norm;
   logic [DIV_W-1:0]     div_norm;

   assign width_norm = CNT_W'(norm_width(32'(width), MAX_WIDTH));
   assign div_norm   = DIV_W'(norm_div(32'(div)));

   spi_clk_gen #(
      .DIV_W (DIV_W),
      .TGL_W (CNT_W + 1)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .run      (cg_run),
      .tgl_en   (state == SHIFT),
      .div_in   (div_norm),
      .ntog_in  ({width_norm, 1'b0}),
      .cpol_in  (mode_nxt.cpol),
      .sclk     (SCLK),
      .tick     (tick),
      .tgl      (tgl),
      .tgl_odd  (tgl_odd),
      .tgl_last (tgl_last)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cg_run    = 1'b0;
      mode_nxt  = mode_q;
      case (state)
         IDLE: begin
            if (wrt) begin
               accept        = 1'b1;
               mode_nxt.cpol = cpol;
               mode_nxt.cpha = cpha;
               // A held slave select skips the setup wait.
               state_nxt     = ss_n_q ? SETUP : SHIFT;
            end
         end
         SETUP: begin
            cg_run = 1'b1;
            if (tick) state_nxt = SHIFT;
         end
         SHIFT: begin
            cg_run = 1'b1;
            if (tgl && tgl_last) state_nxt = TRAIL;
         end
         TRAIL: begin
            cg_run = 1'b1;
            if (tick) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cpha=0 samples odd toggles and shifts non-final even ones; cpha=1 is the reverse.
   assign do_sample = tgl && (mode_q.cpha ? ~tgl_odd : tgl_odd);
   assign do_shift  = tgl && (mode_q.cpha ? tgl_odd : (~tgl_odd && ~tgl_last));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= '0;
         hold_q    <= 1'b0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         ss_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         data_in_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         mode_q <= mode_nxt;
         busy_q <= (state_nxt == SETUP) || (state_nxt == SHIFT) || (state_nxt == TRAIL);
         done_q <= (state_nxt == DONE);
         if (accept) begin
            hold_q <= hold_ss;
            // With cpha=1 the first odd toggle re-presents bit 0, so no pre-shift.
            tx_sh  <= cpha ? data_out : (data_out << 1);
            rx_sh  <= '0;
            ss_n_q <= 1'b0;
            mosi_q <= data_out[MAX_WIDTH-1];
         end else if (state_nxt == DONE) begin
            data_in_q <= rx_sh;
            ss_n_q    <= ~hold_q;
            mosi_q    <= 1'b0;
         end else begin
            if (do_shift) begin
               mosi_q <= tx_sh[MAX_WIDTH-1];
               tx_sh  <= tx_sh << 1;
            end
            if (do_sample) rx_sh <= {rx_sh[MAX_WIDTH-2:0], MISO};
         end
      end
   end

   assign SS_n    = ss_n_q;
   assign MOSI    = mosi_q;
   assign data_in = data_in_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_mstr_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_mstr_gen : vector-table bench with an SPI slave model for spi_mstr_gen. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_mstr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrt;
   logic [15:0] data_out;
   logic [4:0]  width;
   logic        cpol, cpha;
   logic [7:0]  div;
   logic        hold_ss;
   logic        miso;
   logic        SS_n, SCLK, MOSI;
   logic [15:0] data_in;
   logic        busy, done;

   logic        loopb;
   logic        miso_s;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          n_done = 0;

   assign miso = loopb ? MOSI : miso_s;

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) n_done++;

   spi_mstr_gen dut (
      .clk      (clk),
      .rst      (rst),
      .wrt      (wrt),
      .data_out (data_out),
      .width    (width),
      .cpol     (cpol),
      .cpha     (cpha),
      .div      (div),
      .hold_ss  (hold_ss),
      .MISO     (miso),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      logic [15:0] dout;
      logic [4:0]  wid;
      logic        cp;
      logic        ch;
      logic [7:0]  dv;
      logic        hold;
      logic        lp;
      logic [15:0] spat;
      logic [15:0] exp_tx;
      logic [15:0] exp_rx;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Runs one frame; the slave model records MOSI and drives MISO on the mode's edges.
   task automatic run_frame(input vec_t v, input int id, input int mid_at, input bit wrt_in_done);
      int          nb, lat, tog, rises, sidx, ss_low;
      logic [15:0] slv_rx;
      logic        prev_sclk, prev_mosi;
      bit          busy_ok;
      nb       = ((v.wid == 5'd0) || (v.wid > 5'd16)) ? 16 : int'(v.wid);
      data_out = v.dout;
      width    = v.wid;
      cpol     = v.cp;
      cpha     = v.ch;
      div      = v.dv;
      hold_ss  = v.hold;
      loopb    = v.lp;
      sidx     = nb - 1;
      slv_rx   = '0;
      if (!v.ch) begin
         miso_s = v.spat[sidx];
         sidx--;
      end
      wrt = 1'b1;
      @(posedge clk); #1;
      wrt      = 1'b0;
      data_out = ~v.dout;
      width    = 5'd3;
      cpol     = ~v.cp;
      cpha     = ~v.ch;
      div      = 8'd7;
      hold_ss  = ~v.hold;
      chk($sformatf("v%0d.sclk_start", id), SCLK, v.cp);
      lat = 1; tog = 0; rises = 0; ss_low = 0; busy_ok = 1'b1;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
      while (done !== 1'b1 && lat < 3000) begin
         if (SS_n === 1'b0) ss_low++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         wrt = (mid_at != 0 && lat == mid_at);
         @(posedge clk); #1;
         lat++;
         if (SCLK !== prev_sclk) begin
            tog++;
            if (SCLK === 1'b1) rises++;
            if (((tog % 2) == 1) != v.ch) begin
               slv_rx = {slv_rx[14:0], prev_mosi};
            end else if (!v.lp && tog < 2 * nb && sidx >= 0) begin
               miso_s = v.spat[sidx];
               sidx--;
            end
         end
         prev_sclk = SCLK;
         prev_mosi = MOSI;
      end
      wrt = 1'b0;
      chk($sformatf("v%0d.latency", id), lat, v.lat);
      chk($sformatf("v%0d.data_in", id), data_in, v.exp_rx);
      chk($sformatf("v%0d.slave_rx", id), slv_rx, v.exp_tx);
      chk($sformatf("v%0d.sclk_rises", id), rises, nb);
      chk($sformatf("v%0d.ss_low_cycles", id), ss_low, v.lat - 1);
      chk($sformatf("v%0d.busy_during", id), busy_ok, 1);
      chk($sformatf("v%0d.busy_at_done", id), busy, 0);
      chk($sformatf("v%0d.sclk_end", id), SCLK, v.cp);
      chk($sformatf("v%0d.ss_at_done", id), SS_n, !v.hold);
      chk($sformatf("v%0d.mosi_at_done", id), MOSI, 0);
      wrt = wrt_in_done;
      @(posedge clk); #1;
      wrt = 1'b0;
      chk($sformatf("v%0d.done_width", id), done, 0);
      chk($sformatf("v%0d.ss_idle", id), SS_n, !v.hold);
      chk($sformatf("v%0d.sclk_idle", id), SCLK, v.cp);
   endtask

   vec_t tbl[13];
   vec_t vw, vr;
   int   n0, extra, tog, cyc;
   logic prev;

   initial begin
      //           dout      wid   cp ch dv    hd lp spat      exp_tx    exp_rx    lat
      tbl[0]  = '{16'h6600, 5'd8,  0, 0, 8'd2, 0, 1, 16'h0000, 16'h0066, 16'h0066, 37};
      tbl[1]  = '{16'hA5C3, 5'd16, 0, 0, 8'd1, 0, 1, 16'h0000, 16'hA5C3, 16'hA5C3, 35};
      tbl[2]  = '{16'hA5C3, 5'd16, 0, 1, 8'd1, 0, 1, 16'h0000, 16'hA5C3, 16'hA5C3, 35};
      tbl[3]  = '{16'hA5C3, 5'd16, 1, 0, 8'd1, 0, 1, 16'h0000, 16'hA5C3, 16'hA5C3, 35};
      tbl[4]  = '{16'hA5C3, 5'd16, 1, 1, 8'd1, 0, 1, 16'h0000, 16'hA5C3, 16'hA5C3, 35};
      tbl[5]  = '{16'h1234, 5'd0,  0, 0, 8'd0, 0, 1, 16'h0000, 16'h1234, 16'h1234, 35};
      tbl[6]  = '{16'h8001, 5'd20, 1, 1, 8'd0, 0, 1, 16'h0000, 16'h8001, 16'h8001, 35};
      tbl[7]  = '{16'hF000, 5'd8,  0, 1, 8'd3, 0, 0, 16'h0096, 16'h00F0, 16'h0096, 55};
      tbl[8]  = '{16'hA800, 5'd5,  0, 0, 8'd1, 0, 0, 16'h000C, 16'h0015, 16'h000C, 13};
      tbl[9]  = '{16'h4000, 5'd3,  1, 0, 8'd2, 0, 0, 16'h0005, 16'h0002, 16'h0005, 17};
      tbl[10] = '{16'h0000, 5'd1,  1, 1, 8'd1, 0, 0, 16'h0001, 16'h0000, 16'h0001, 5};
      tbl[11] = '{16'h9000, 5'd4,  0, 0, 8'd2, 1, 1, 16'h0000, 16'h0009, 16'h0009, 21};
      tbl[12] = '{16'h6000, 5'd4,  0, 0, 8'd2, 0, 1, 16'h0000, 16'h0006, 16'h0006, 19};
      vw      = '{16'h3C00, 5'd8,  0, 0, 8'd1, 0, 1, 16'h0000, 16'h003C, 16'h003C, 19};
      vr      = '{16'h5A00, 5'd8,  1, 0, 8'd1, 0, 1, 16'h0000, 16'h005A, 16'h005A, 19};

      rst = 1'b1; wrt = 1'b0; data_out = '0; width = '0; cpol = 1'b0; cpha = 1'b0;
      div = '0; hold_ss = 1'b0; loopb = 1'b1; miso_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.SS_n", SS_n, 1);
      chk("reset.SCLK", SCLK, 0);
      chk("reset.MOSI", MOSI, 0);
      chk("reset.data_in", data_in, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      n0 = n_done;
      for (int i = 0; i < 13; i++) run_frame(tbl[i], i, 0, 1'b0);
      chk("table.done_count", n_done - n0, 13);

      // wrt mid-frame and during the DONE cycle must both be dropped.
      n0 = n_done;
      run_frame(vw, 20, 6, 1'b1);
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0) extra++;
      end
      chk("ignored_wrt.activity", extra, 0);
      chk("ignored_wrt.done_count", n_done - n0, 1);

      // Reset at the fifth SCLK toggle of an 8-bit frame.
      data_out = 16'hFF00; width = 5'd8; cpol = 1'b0; cpha = 1'b0; div = 8'd2;
      hold_ss = 1'b0; loopb = 1'b1;
      n0 = n_done;
      wrt = 1'b1;
      @(posedge clk); #1;
      wrt = 1'b0;
      prev = SCLK; tog = 0; cyc = 0;
      while (tog < 5 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (SCLK !== prev) tog++;
         prev = SCLK;
      end
      chk("rst_mid.reached_toggle5", tog, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid.SS_n", SS_n, 1);
      chk("rst_mid.SCLK", SCLK, 0);
      chk("rst_mid.MOSI", MOSI, 0);
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.done", done, 0);
      chk("rst_mid.data_in", data_in, 0);
      rst = 1'b0;
      extra = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (SS_n !== 1'b1 || busy !== 1'b0) extra++;
      end
      chk("rst_mid.quiet_after", extra, 0);
      chk("rst_mid.no_done", n_done - n0, 0);
      run_frame(vr, 21, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
